// File: rtl/i2c_seq_pkg.sv
// rtl/i2c_seq_pkg.sv - shared types for the I2C command sequencer
package i2c_seq_pkg;

    typedef struct packed {
        logic       op;
        logic [6:0] addr;
        logic [7:0] wdata;
    } i2c_cmd_t;

    typedef struct packed {
        logic       op;
        logic [7:0] rdata;
        logic       ack_err;
        logic       timeout;
    } i2c_rsp_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } seq_state_t;

    localparam int CMD_W = $bits(i2c_cmd_t);
    localparam int RSP_W = $bits(i2c_rsp_t);

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// rtl/i2c_cmd_sequencer_if.sv - host command/response and I2C master handshake bundle
interface i2c_cmd_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_op;
    logic [7:0] rsp_rdata;
    logic       rsp_ack_err;
    logic       rsp_timeout;

    logic       i2c_newd;
    logic       i2c_op;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_din;
    logic [7:0] i2c_dout;
    logic       i2c_busy;
    logic       i2c_ack_err;
    logic       i2c_done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        input  i2c_dout, i2c_busy, i2c_ack_err, i2c_done,
        output cmd_ready, rsp_valid, rsp_op, rsp_rdata, rsp_ack_err, rsp_timeout,
        output i2c_newd, i2c_op, i2c_addr, i2c_din
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        output i2c_dout, i2c_busy, i2c_ack_err, i2c_done,
        input  cmd_ready, rsp_valid, rsp_op, rsp_rdata, rsp_ack_err, rsp_timeout,
        input  i2c_newd, i2c_op, i2c_addr, i2c_din
    );

endinterface

// File: rtl/i2c_seq_fifo.sv
// rtl/i2c_seq_fifo.sv - first-word-fall-through FIFO used for command and response queues
module i2c_seq_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_ready,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_valid && !full;
    assign do_rd = rd_ready && !empty;

    // Head is forced to zero when empty so consumers never see stale entries.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// rtl/i2c_cmd_sequencer.sv - queues host I2C requests, issues them one at a time, returns results
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    i2c_cmd_sequencer_if.slave   bus,
    output logic                 idle
);

    localparam int CNT_W = $clog2(TIMEOUT);

    seq_state_t                 state;
    i2c_cmd_t                   cmd_in;
    i2c_cmd_t                   cmd_head;
    logic                       cmd_full;
    logic                       cmd_empty;
    logic [$clog2(CMD_DEPTH):0] cmd_count;
    logic                       cmd_pop;

    i2c_rsp_t                   rsp_q;
    i2c_rsp_t                   rsp_head;
    logic                       rsp_full;
    logic                       rsp_empty;
    logic [$clog2(RSP_DEPTH):0] rsp_count;
    logic                       rsp_push;

    logic                       newd_q;
    logic                       op_q;
    logic [6:0]                 addr_q;
    logic [7:0]                 din_q;
    logic                       sticky_err;
    logic [CNT_W-1:0]           wait_cnt;
    logic                       start;

    assign cmd_in = '{op: bus.cmd_op, addr: bus.cmd_addr, wdata: bus.cmd_wdata};

    i2c_seq_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (bus.cmd_valid),
        .wr_data  (cmd_in),
        .rd_ready (cmd_pop),
        .rd_data  (cmd_head),
        .full     (cmd_full),
        .empty    (cmd_empty),
        .count    (cmd_count)
    );

    i2c_seq_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (rsp_push),
        .wr_data  (rsp_q),
        .rd_ready (bus.rsp_ready),
        .rd_data  (rsp_head),
        .full     (rsp_full),
        .empty    (rsp_empty),
        .count    (rsp_count)
    );

    // Reserving a response slot before issuing means RESP can always push.
    assign start    = !cmd_empty && !bus.i2c_busy && (rsp_count < ($clog2(RSP_DEPTH)+1)'(RSP_DEPTH));
    assign cmd_pop  = (state == IDLE) && start;
    assign rsp_push = (state == RESP);

    assign bus.cmd_ready   = !cmd_full;
    assign bus.rsp_valid   = !rsp_empty;
    assign bus.rsp_op      = rsp_head.op;
    assign bus.rsp_rdata   = rsp_head.rdata;
    assign bus.rsp_ack_err = rsp_head.ack_err;
    assign bus.rsp_timeout = rsp_head.timeout;
    assign bus.i2c_newd    = newd_q;
    assign bus.i2c_op      = op_q;
    assign bus.i2c_addr    = addr_q;
    assign bus.i2c_din     = din_q;
    assign idle            = (state == IDLE) && (cmd_count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            newd_q     <= 1'b0;
            op_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            sticky_err <= 1'b0;
            wait_cnt   <= '0;
            rsp_q      <= '0;
        end else begin
            newd_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q       <= cmd_head.op;
                        addr_q     <= cmd_head.addr;
                        din_q      <= cmd_head.wdata;
                        sticky_err <= 1'b0;
                        newd_q     <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    sticky_err <= sticky_err | bus.i2c_ack_err;
                    wait_cnt   <= wait_cnt + CNT_W'(1);
                    // A completion arriving on the last allowed cycle still wins.
                    if (bus.i2c_done) begin
                        rsp_q <= '{op:      op_q,
                                   rdata:   op_q ? bus.i2c_dout : 8'h00,
                                   ack_err: sticky_err | bus.i2c_ack_err,
                                   timeout: 1'b0};
                        state <= RESP;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_q <= '{op:      op_q,
                                   rdata:   8'h00,
                                   ack_err: sticky_err,
                                   timeout: 1'b1};
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    rsp_no_overflow: assert property (@(posedge clk) disable iff (!rst) rsp_push |-> !rsp_full);

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb/tb_i2c_cmd_sequencer.sv - self-checking bench for i2c_cmd_sequencer
module tb_i2c_cmd_sequencer;
    import i2c_seq_pkg::*;

    localparam int CD = 4;
    localparam int RD = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic idle;
    always #5 clk = ~clk;

    i2c_cmd_sequencer_if bus ();

    i2c_cmd_sequencer #(.CMD_DEPTH(CD), .RSP_DEPTH(RD), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .idle (idle)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int newd_cnt = 0;
    int newd_cyc = 0;

    logic m_busy = 1'b0;
    logic force_busy = 1'b0;
    assign bus.i2c_busy = m_busy | force_busy;

    int cfg_lat  = 2;
    int cfg_ack  = 0;
    bit cfg_hang = 1'b0;
    bit rnd_mode = 1'b0;

    logic [7:0] mem [128];
    i2c_cmd_t   cmd_q [$];
    i2c_rsp_t   exp_q [$];

    typedef struct {
        logic       op;
        logic [6:0] addr;
        logic [7:0] wdata;
        int         lat;
        int         am;
        bit         hang;
        logic [7:0] e_rdata;
        logic       e_ack;
        logic       e_to;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.i2c_newd) begin
                newd_cnt++;
                newd_cyc = cyc;
                chk("newd_single_cycle", prev, 0);
            end
            prev = bus.i2c_newd;
        end
    end

    // Master + slave model: serves each newd per the current config and predicts the response.
    initial begin
        i2c_cmd_t c;
        i2c_rsp_t r;
        int lat;
        int am;
        bit hg;
        bus.i2c_done    = 1'b0;
        bus.i2c_ack_err = 1'b0;
        bus.i2c_dout    = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (rst && bus.i2c_newd) begin
                c = '{op: bus.i2c_op, addr: bus.i2c_addr, wdata: bus.i2c_din};
                if (rnd_mode) begin
                    hg  = ($urandom_range(0, 7) == 0);
                    lat = hg ? $urandom_range(1, 10) : $urandom_range(1, 16);
                    am  = $urandom_range(0, 2);
                end else begin
                    lat = cfg_lat;
                    am  = cfg_ack;
                    hg  = cfg_hang;
                end
                if (cmd_q.size() == 0) begin
                    chk("issue_unexpected", 1, 0);
                end else begin
                    chk("issue_cmd", c, cmd_q.pop_front());
                end
                r.op      = c.op;
                r.timeout = hg;
                r.rdata   = (c.op && !hg) ? mem[c.addr] : 8'h00;
                r.ack_err = (am == 1 && lat >= 2) || (am == 2 && !hg);
                exp_q.push_back(r);
                m_busy = 1'b1;
                for (int i = 0; i < lat; i++) begin
                    bus.i2c_ack_err = (am == 1 && i > 0 && i == lat - 1);
                    @(posedge clk); #1;
                end
                bus.i2c_ack_err = 1'b0;
                if (!hg) begin
                    chk("i2c_fields_stable", {bus.i2c_op, bus.i2c_addr, bus.i2c_din}, c);
                    bus.i2c_done    = 1'b1;
                    bus.i2c_ack_err = (am == 2);
                    bus.i2c_dout    = c.op ? mem[c.addr] : 8'hEE;
                    if (!c.op) mem[c.addr] = c.wdata;
                    @(posedge clk); #1;
                    bus.i2c_done    = 1'b0;
                    bus.i2c_ack_err = 1'b0;
                    bus.i2c_dout    = 8'h00;
                end
                m_busy = 1'b0;
            end
        end
    end

    task automatic push(input logic op, input logic [6:0] a, input logic [7:0] d, output bit acc);
        acc = bus.cmd_ready;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        if (acc) cmd_q.push_back('{op: op, addr: a, wdata: d});
    endtask

    task automatic push_wait(input logic op, input logic [6:0] a, input logic [7:0] d);
        int k;
        bit acc;
        k = 0;
        while (!bus.cmd_ready && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        if (!bus.cmd_ready) chk("push_wait_timeout", 0, 1);
        else push(op, a, d, acc);
    endtask

    task automatic pop(output i2c_rsp_t got, output int seen);
        int k;
        k = 0;
        while (!bus.rsp_valid && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (!bus.rsp_valid) begin
            chk("rsp_wait_timeout", 0, 1);
            got  = '0;
            seen = -1;
        end else begin
            got  = '{op: bus.rsp_op, rdata: bus.rsp_rdata, ack_err: bus.rsp_ack_err, timeout: bus.rsp_timeout};
            seen = cyc;
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0;
            if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
            else chk("rsp_vs_model", got, exp_q.pop_front());
        end
    endtask

    initial begin
        vec_t     tbl [10];
        i2c_rsp_t got;
        int       seen;
        int       n0;
        bit       acc;
        bit       saw_rsp;
        int       n_acc;
        int       n_rcv;
        bit       prod_done;

        tbl[0] = '{1'b0, 7'h12, 8'hA5, 3,  0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 7'h05, 8'h3C, 2,  0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 7'h05, 8'h00, 4,  0, 1'b0, 8'h3C, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 7'h12, 8'h99, 1,  0, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 7'h20, 8'h77, 5,  1, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 7'h20, 8'h00, 2,  2, 1'b0, 8'h77, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 7'h05, 8'h00, 4,  0, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 7'h12, 8'h00, 16, 0, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 7'h7F, 8'hFF, 3,  1, 1'b1, 8'h00, 1'b1, 1'b1};
        tbl[9] = '{1'b1, 7'h7F, 8'h00, 1,  0, 1'b0, 8'h25, 1'b0, 1'b0};

        for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", bus.cmd_ready, 1);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_idle", idle, 1);
        chk("reset_i2c_outs", {bus.i2c_newd, bus.i2c_op, bus.i2c_addr, bus.i2c_din}, 0);
        chk("reset_rsp_fields", {bus.rsp_op, bus.rsp_rdata, bus.rsp_ack_err, bus.rsp_timeout}, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            cfg_lat  = tbl[i].lat;
            cfg_ack  = tbl[i].am;
            cfg_hang = tbl[i].hang;
            n0 = newd_cnt;
            push(tbl[i].op, tbl[i].addr, tbl[i].wdata, acc);
            chk("tbl_accept", acc, 1);
            pop(got, seen);
            chk("tbl_rsp", got, {tbl[i].op, tbl[i].e_rdata, tbl[i].e_ack, tbl[i].e_to});
            chk("tbl_newd_count", newd_cnt - n0, 1);
            // Response lands lat+2 cycles after newd; a watchdog abort after TO WAIT cycles + RESP.
            chk("tbl_latency", seen - newd_cyc, tbl[i].hang ? TO + 2 : tbl[i].lat + 2);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("idle_after_table", idle, 1);

        cfg_lat = 2; cfg_ack = 0; cfg_hang = 1'b0;
        force_busy = 1'b1;
        n0 = newd_cnt;
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 7'h40 + 7'(i), 8'(8'h10 + i), acc);
            chk("full_accept", acc, (i < 4));
        end
        chk("full_cmd_ready", bus.cmd_ready, 0);
        chk("full_idle", idle, 0);
        chk("full_no_issue", newd_cnt - n0, 0);
        force_busy = 1'b0;
        for (int i = 0; i < 4; i++) pop(got, seen);
        chk("full_issue_count", newd_cnt - n0, 4);

        cfg_lat = 1;
        n0 = newd_cnt;
        for (int i = 0; i < 6; i++) push_wait(1'(i % 2), 7'h40 + 7'(i % 3), 8'(8'hC0 + i));
        repeat (40) @(posedge clk);
        #1;
        chk("bp_stall_issues", newd_cnt - n0, RD);
        chk("bp_rsp_valid", bus.rsp_valid, 1);
        chk("bp_idle", idle, 0);
        for (int i = 0; i < 6; i++) pop(got, seen);
        chk("bp_all_issued", newd_cnt - n0, 6);

        cfg_hang = 1'b1; cfg_lat = 8;
        n0 = newd_cnt;
        for (int i = 0; i < 3; i++) push(1'b0, 7'h33, 8'(i), acc);
        repeat (4) @(posedge clk);
        #3;
        chk("rst_in_wait", newd_cnt - n0, 1);
        rst = 1'b0;
        #1;
        chk("arst_i2c_outs", {bus.i2c_newd, bus.i2c_op, bus.i2c_addr, bus.i2c_din}, 0);
        chk("arst_cmd_ready", bus.cmd_ready, 1);
        chk("arst_rsp_valid", bus.rsp_valid, 0);
        chk("arst_idle", idle, 1);
        cmd_q.delete();
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        n0 = newd_cnt;
        saw_rsp = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) saw_rsp = 1'b1;
        end
        chk("post_rst_no_rsp", saw_rsp, 0);
        chk("post_rst_no_newd", newd_cnt - n0, 0);
        cfg_hang = 1'b0; cfg_lat = 3;
        push(1'b1, 7'h12, 8'h00, acc);
        pop(got, seen);
        chk("post_rst_rsp", got, {1'b1, 8'hA5, 1'b0, 1'b0});

        rnd_mode  = 1'b1;
        n_acc     = 0;
        n_rcv     = 0;
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    push_wait(1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom));
                    n_acc++;
                end
                prod_done = 1'b1;
            end
            begin
                for (int k = 0; k < 20000 && !(prod_done && n_rcv == n_acc); k++) begin
                    bus.rsp_ready = 1'($urandom_range(0, 1));
                    if (bus.rsp_valid && bus.rsp_ready) begin
                        got = '{op: bus.rsp_op, rdata: bus.rsp_rdata, ack_err: bus.rsp_ack_err, timeout: bus.rsp_timeout};
                        if (exp_q.size() == 0) chk("rnd_rsp_unexpected", 1, 0);
                        else chk("rnd_rsp", got, exp_q.pop_front());
                        n_rcv++;
                    end
                    @(posedge clk); #1;
                end
                bus.rsp_ready = 1'b0;
            end
        join
        chk("rnd_drained", n_rcv, n_acc);
        chk("rnd_model_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
